// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches the word at the PC and hands it to the decoder, then strobes the PC to advance
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  pc_load,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [INST_WIDTH-1:0] mem_rdata,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic [31:0]           fetch_count
);
  typedef enum logic [2:0] {IDLE, REQ, HOLD, STEP, FAULT} state_t;
  state_t                r_state, w_next;
  logic                  r_pc_load, r_mem_req, r_inst_valid, r_fault;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [INST_WIDTH-1:0] r_inst, w_inst;
  logic [1:0]            r_code, w_code;
  logic [31:0]           r_fc, w_fc;
  logic [7:0]            r_cnt, w_cnt;
  logic                  w_cap, w_mis, w_to;
  // state register
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  // next state: IDLE and STEP both launch a fetch of the current PC; ack beats timeout
  always_comb begin
    w_cap  = r_state == IDLE || r_state == STEP;
    w_mis  = |pc_addr[1:0];
    w_to   = r_cnt == 8'(TIMEOUT - 1);
    w_next = w_cap              ? (w_mis ? FAULT : REQ) :
             r_state == REQ     ? (mem_ack ? HOLD : w_to ? FAULT : REQ) :
             r_state == HOLD    ? (inst_ready ? STEP : HOLD) : FAULT;
  end
  // next values of the datapath registers; FAULT freezes everything
  always_comb begin
    w_mem_addr = w_cap ? pc_addr : r_mem_addr;
    w_cnt      = w_cap ? 8'd0 : (r_state == REQ && !mem_ack) ? r_cnt + 8'd1 : r_cnt;
    w_inst     = (r_state == REQ && mem_ack) ? mem_rdata : r_inst;
    w_fc       = (r_state == HOLD && inst_ready) ? r_fc + 32'd1 : r_fc;
    w_code     = (w_next == FAULT && r_state != FAULT) ? (w_cap ? 2'b01 : 2'b10) : r_code;
  end
  // registered outputs follow the state being entered
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_pc_load    <= 1'b0;
      r_mem_req    <= 1'b0;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_mem_addr   <= '0;
      r_inst       <= '0;
      r_code       <= 2'b00;
      r_fc         <= 32'd0;
      r_cnt        <= 8'd0;
    end else begin
      r_pc_load    <= w_next == STEP;
      r_mem_req    <= w_next == REQ;
      r_inst_valid <= w_next == HOLD;
      r_fault      <= w_next == FAULT;
      r_mem_addr   <= w_mem_addr;
      r_inst       <= w_inst;
      r_code       <= w_code;
      r_fc         <= w_fc;
      r_cnt        <= w_cnt;
    end
  assign pc_load     = r_pc_load;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign inst        = r_inst;
  assign inst_valid  = r_inst_valid;
  assign fault       = r_fault;
  assign fault_code  = r_code;
  assign fetch_count = r_fc;
endmodule
